vanilla_arb_merge_buffer: RTL and testbench

- Sits directly downstream of the 2-way round-robin request arbiter in the vanilla core.
- Supplies the arbiter's yumi (space available) and accepts its one-hot grant.
- Muxes the granted source's payload into an els_p-deep output FIFO and presents it to the consumer on a valid/yumi interface.
- Acks the granted source in the same cycle and records a sticky protocol-error flag.

---
 rtl/vanilla_arb_pkg.sv | 8 +
 rtl/vanilla_arb_merge_fifo.sv | 46 ++++
 rtl/vanilla_arb_merge_buffer.sv | 98 +++++++++
 tb/tb_vanilla_arb_merge_buffer.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/vanilla_arb_pkg.sv
// Shared types for the vanilla core arbiter merge path.
package vanilla_arb_pkg;

  localparam int num_arb_src_gp = 2;

  typedef logic arb_src_id_t;

endpackage

// File: rtl/vanilla_arb_merge_fifo.sv
// Circular buffer holding granted arbiter entries; storage itself is not reset.
module vanilla_arb_merge_fifo #(
  parameter int width_p = 33,
  parameter int els_p   = 2,
  localparam int lg_els_lp = $clog2(els_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 enq_i,
  input  logic [width_p-1:0]   data_i,
  input  logic                 deq_i,
  output logic [width_p-1:0]   data_o,
  output logic [lg_els_lp:0]   count_o,
  output logic                 full_o,
  output logic                 empty_o
);

  logic [width_p-1:0]   r_mem [els_p];
  logic [lg_els_lp-1:0] r_wptr;
  logic [lg_els_lp-1:0] r_rptr;
  logic [lg_els_lp:0]   r_count;

  // Pointers wrap naturally because els_p is a power of two.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (enq_i) r_wptr <= r_wptr + 1'b1;
      if (deq_i) r_rptr <= r_rptr + 1'b1;
      if (enq_i && !deq_i)      r_count <= r_count + 1'b1;
      else if (!enq_i && deq_i) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq_i) r_mem[r_wptr] <= data_i;
  end

  assign data_o  = r_mem[r_rptr];
  assign count_o = r_count;
  assign full_o  = (r_count == (lg_els_lp+1)'(els_p));
  assign empty_o = (r_count == '0);

endmodule

// File: rtl/vanilla_arb_merge_buffer.sv
// Merges the round-robin arbiter's granted source into an output FIFO,
// acks the source, and flags protocol violations with a sticky error.
module vanilla_arb_merge_buffer
  import vanilla_arb_pkg::*;
#(
  parameter int data_width_p = 32,
  parameter int els_p        = 2,
  parameter bit assert_en_p  = 1'b1,
  localparam int lg_els_lp   = $clog2(els_p)
) (
  input  logic                                        clk_i,
  input  logic                                        reset_i,
  input  logic [num_arb_src_gp-1:0]                   v_i,
  input  logic [num_arb_src_gp-1:0][data_width_p-1:0] data_i,
  input  logic [num_arb_src_gp-1:0]                   grants_i,
  input  logic                                        arb_v_i,
  output logic                                        arb_yumi_o,
  output logic [num_arb_src_gp-1:0]                   src_yumi_o,
  output logic                                        v_o,
  output logic [data_width_p-1:0]                     data_o,
  output logic                                        src_id_o,
  input  logic                                        yumi_i,
  output logic [lg_els_lp:0]                          count_o,
  output logic                                        error_o
);

  typedef struct packed {
    arb_src_id_t             src_id;
    logic [data_width_p-1:0] data;
  } merge_entry_s;

  logic         w_full;
  logic         w_empty;
  logic         w_grant_onehot;
  logic         w_grant_bad_src;
  logic         w_enq;
  logic         w_deq;
  logic         w_err;
  arb_src_id_t  w_src_id;
  merge_entry_s w_wr_entry;
  merge_entry_s w_rd_entry;
  logic         r_error;

  // Space-available must not look at grants_i, otherwise it loops through the arbiter.
  assign arb_yumi_o = arb_v_i & ~w_full & ~reset_i;
  assign src_yumi_o = grants_i & {num_arb_src_gp{arb_yumi_o}};

  assign w_grant_onehot  = (grants_i == 2'b01) || (grants_i == 2'b10);
  assign w_grant_bad_src = |(grants_i & ~v_i);
  assign w_src_id        = arb_src_id_t'(grants_i[1]);
  assign w_enq           = arb_yumi_o & w_grant_onehot & ~w_grant_bad_src;
  assign w_deq           = yumi_i & v_o;

  assign w_wr_entry.src_id = w_src_id;
  assign w_wr_entry.data   = data_i[w_src_id];

  assign w_err = (grants_i == 2'b11)
               | ((grants_i != 2'b00) & ~arb_yumi_o)
               | w_grant_bad_src
               | (yumi_i & ~v_o);

  vanilla_arb_merge_fifo #(
    .width_p ($bits(merge_entry_s)),
    .els_p   (els_p)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .enq_i   (w_enq),
    .data_i  (w_wr_entry),
    .deq_i   (w_deq),
    .data_o  (w_rd_entry),
    .count_o (count_o),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_error <= 1'b0;
    else if (w_err) r_error <= 1'b1;
  end

  assign v_o      = ~w_empty;
  assign data_o   = w_rd_entry.data;
  assign src_id_o = w_rd_entry.src_id;
  assign error_o  = r_error;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (assert_en_p && !reset_i) begin
      assert (grants_i != 2'b11) else $error("grant to both sources");
      assert (!((grants_i != 2'b00) && !arb_yumi_o)) else $error("grant without arb_yumi");
      assert (!w_grant_bad_src) else $error("grant to idle source");
      assert (!(yumi_i && !v_o)) else $error("yumi with empty buffer");
    end
  end
`endif

endmodule

// File: tb/tb_vanilla_arb_merge_buffer.sv
// Self-checking bench: directed scenarios plus a randomized legal arbiter/consumer
// compared against a queue-based reference model.
module tb_vanilla_arb_merge_buffer;

  localparam int DW  = 32;
  localparam int ELS = 2;

  logic                clk = 1'b0;
  logic                reset_i;
  logic [1:0]          v_i;
  logic [1:0][DW-1:0]  data_i;
  logic [1:0]          grants_i;
  logic                arb_v_i;
  logic                arb_yumi_o;
  logic [1:0]          src_yumi_o;
  logic                v_o;
  logic [DW-1:0]       data_o;
  logic                src_id_o;
  logic                yumi_i;
  logic [1:0]          count_o;
  logic                error_o;

  int checks = 0;
  int failures = 0;

  logic [DW:0] mq[$];
  bit          merr;
  bit          last_src;

  always #5 clk = ~clk;

  vanilla_arb_merge_buffer #(
    .data_width_p (DW),
    .els_p        (ELS),
    .assert_en_p  (1'b0)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .v_i        (v_i),
    .data_i     (data_i),
    .grants_i   (grants_i),
    .arb_v_i    (arb_v_i),
    .arb_yumi_o (arb_yumi_o),
    .src_yumi_o (src_yumi_o),
    .v_o        (v_o),
    .data_o     (data_o),
    .src_id_o   (src_id_o),
    .yumi_i     (yumi_i),
    .count_o    (count_o),
    .error_o    (error_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    logic [DW:0] head;
    chk({tag, ".v_o"}, 64'(v_o), 64'(mq.size() > 0));
    chk({tag, ".count"}, 64'(count_o), 64'(mq.size()));
    chk({tag, ".error"}, 64'(error_o), 64'(merr));
    if (mq.size() > 0) begin
      head = mq[0];
      chk({tag, ".data"}, 64'(data_o), 64'(head[DW-1:0]));
      chk({tag, ".src_id"}, 64'(src_id_o), 64'(head[DW]));
    end
  endtask

  // One clock of stimulus: check combinational acks before the edge, state after it.
  task automatic cycle(input string tag, input logic [1:0] v, input logic [1:0] g,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic y);
    bit ay, enq, deq, e;
    v_i = v; arb_v_i = |v; grants_i = g; data_i[0] = d0; data_i[1] = d1; yumi_i = y;
    #3;
    ay  = (|v) && (mq.size() < ELS);
    chk({tag, ".arb_yumi"}, 64'(arb_yumi_o), 64'(ay));
    chk({tag, ".src_yumi"}, 64'(src_yumi_o), 64'(g & {2{ay}}));
    enq = ay && (g == 2'b01 || g == 2'b10) && ((g & v) != 0);
    deq = y && (mq.size() > 0);
    e   = (g == 2'b11) || (g != 2'b00 && !ay) || ((g & ~v) != 0) || (y && mq.size() == 0);
    @(posedge clk); #1;
    if (deq) void'(mq.pop_front());
    if (enq) mq.push_back({g[1], g[1] ? d1 : d0});
    if (e) merr = 1'b1;
    chk_state(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset(input string tag);
    v_i = 2'b11; arb_v_i = 1'b1; grants_i = 2'b00; yumi_i = 1'b0;
    #2 reset_i = 1'b1;
    #1;
    mq.delete(); merr = 1'b0; last_src = 1'b1;
    chk({tag, ".rst_arb_yumi"}, 64'(arb_yumi_o), 64'd0);
    chk({tag, ".rst_src_yumi"}, 64'(src_yumi_o), 64'd0);
    chk_state({tag, ".rst"});
    #1 reset_i = 1'b0;
  endtask

  initial begin
    logic [1:0] v, g;
    logic       y;
    reset_i = 1'b1; v_i = '0; arb_v_i = 1'b0; grants_i = '0; yumi_i = 1'b0; data_i = '0;
    merr = 1'b0; last_src = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;
    chk_state("reset");

    for (int i = 0; i < 5; i++) cycle("idle", 2'b00, 2'b00, '0, '0, 1'b0);

    cycle("single", 2'b01, 2'b01, 32'hA5, 32'h0, 1'b0);

    do_reset("fill");
    cycle("fill1", 2'b11, 2'b10, 32'h1111, 32'h2222, 1'b0);
    cycle("fill2", 2'b11, 2'b01, 32'h3333, 32'h4444, 1'b0);
    cycle("full_hold", 2'b11, 2'b00, 32'h5555, 32'h6666, 1'b0);
    cycle("full_deq", 2'b11, 2'b00, 32'h5555, 32'h6666, 1'b1);
    cycle("after_deq", 2'b11, 2'b10, 32'h7777, 32'h8888, 1'b0);

    do_reset("stream");
    for (int i = 0; i < 9; i++)
      cycle("stream", 2'b11, (i % 2 == 0) ? 2'b10 : 2'b01, $urandom, $urandom, i > 0);
    cycle("stream_drain", 2'b00, 2'b00, '0, '0, 1'b1);

    do_reset("err11");
    cycle("err11_pre", 2'b01, 2'b01, 32'hCAFE, 32'h0, 1'b0);
    cycle("err11", 2'b11, 2'b11, 32'hDEAD, 32'hBEEF, 1'b0);
    cycle("err11_hold", 2'b00, 2'b00, '0, '0, 1'b0);

    do_reset("erryumi");
    cycle("erryumi", 2'b00, 2'b00, '0, '0, 1'b1);
    cycle("erryumi_enq", 2'b10, 2'b10, 32'h0, 32'h1234, 1'b0);

    do_reset("errsrc");
    cycle("errsrc", 2'b01, 2'b10, 32'h9, 32'hA, 1'b0);

    do_reset("midrst");
    cycle("mid1", 2'b11, 2'b10, 32'hAA, 32'hBB, 1'b0);
    cycle("mid2", 2'b11, 2'b01, 32'hCC, 32'hDD, 1'b0);
    do_reset("midrst2");
    cycle("post_rst", 2'b10, 2'b10, 32'h0, 32'hF00D, 1'b0);

    do_reset("rand");
    for (int i = 0; i < 300; i++) begin
      v = 2'($urandom);
      g = 2'b00;
      if ((|v) && (mq.size() < ELS)) begin
        if (v == 2'b11) g = last_src ? 2'b01 : 2'b10;
        else g = v;
        last_src = g[1];
      end
      y = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
      cycle("rand", v, g, $urandom, $urandom, y);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
